// File: rtl/tick_timer_sched_if.sv
// Configuration, interrupt and status bundle between the register block and tick_timer_sched.
// The master drives configuration/acks; the slave (the scheduler) drives tick/expiry/status.
interface tick_timer_sched_if #(
    parameter int WD  = 10,
    parameter int NCH = 4,
    parameter int CW  = 16
);
    logic [WD-1:0]     cfg_max_cnt;
    logic [NCH-1:0]    cfg_ch_en;
    logic [NCH*CW-1:0] cfg_ch_period;
    logic [NCH-1:0]    cfg_ch_oneshot;
    logic [NCH-1:0]    irq_ack;
    logic              ovr_clr;
    logic              tick;
    logic [NCH-1:0]    expire_pulse;
    logic [NCH-1:0]    irq_pend;
    logic              ovr_err;
    logic              busy;

    modport master (
        output cfg_max_cnt, cfg_ch_en, cfg_ch_period, cfg_ch_oneshot, irq_ack, ovr_clr,
        input  tick, expire_pulse, irq_pend, ovr_err, busy
    );

    modport slave (
        input  cfg_max_cnt, cfg_ch_en, cfg_ch_period, cfg_ch_oneshot, irq_ack, ovr_clr,
        output tick, expire_pulse, irq_pend, ovr_err, busy
    );
endinterface

// File: rtl/tick_timer_sched.sv
// Multi-channel timer scheduler: shared prescaler tick, one channel decremented per cycle during SCAN.
// Optional one-shot channels are built when TICK_SCHED_ONESHOT_EN is defined.
module tick_timer_sched #(
    parameter int WD  = 10,
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              reset,
    tick_timer_sched_if.slave bus
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  w_idx_nx;
    logic           r_tick_pend;
    logic           w_tick_pend_nx;
    logic           w_ovr_set;
    logic           w_scan;

    logic [WD-1:0]  r_cnt;
    logic           r_tick;
    logic           r_ovr_err;
    logic           r_busy;
    logic [NCH-1:0] r_expire;
    logic [NCH-1:0] r_irq_pend;
    logic [NCH-1:0] w_visit;
    logic [NCH-1:0] w_hit;
    logic [NCH-1:0] w_done;
    logic [CW-1:0]  r_ch_cnt [NCH];

    // Prescaler: free-running past a lowered terminal count, wrapping at 2^WD-1 without a tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == bus.cfg_max_cnt) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + WD'(1);
            r_tick <= 1'b0;
        end
    end

    // Sequencer next-state: at most one tick is queued; a tick meeting a full queue is an overrun
    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_tick_pend_nx = r_tick_pend;
        w_ovr_set      = 1'b0;
        w_scan         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_tick) begin
                    w_state_nx = ST_SCAN;
                    w_idx_nx   = '0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SCAN: begin
                w_scan = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_idx_nx = '0;
                    if (r_tick_pend || r_tick) begin
                        w_state_nx     = ST_SCAN;
                        w_tick_pend_nx = 1'b0;
                        // queued tick starts the next scan, so a simultaneous fresh tick is lost
                        w_ovr_set      = r_tick_pend && r_tick;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_idx_nx = r_idx + IW'(1);
                    if (r_tick && r_tick_pend) begin
                        w_ovr_set = 1'b1;
                    end else if (r_tick) begin
                        w_tick_pend_nx = 1'b1;
                    end else begin
                        w_tick_pend_nx = r_tick_pend;
                    end
                end
            end
            default: begin
                w_state_nx     = ST_IDLE;
                w_idx_nx       = '0;
                w_tick_pend_nx = 1'b0;
            end
        endcase
    end

    // Sequencer state, queued tick, overrun flag and busy status
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_tick_pend <= 1'b0;
            r_ovr_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_tick_pend <= w_tick_pend_nx;
            r_ovr_err   <= w_ovr_set | (r_ovr_err & ~bus.ovr_clr);
            r_busy      <= (w_state_nx == ST_SCAN);
        end
    end

    // Per-channel decode of the slot being scanned this cycle
    always_comb begin
        w_visit = '0;
        w_hit   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_visit[k] = w_scan && (r_idx == IW'(k)) && bus.cfg_ch_en[k] && !w_done[k];
            w_hit[k]   = w_visit[k] && (r_ch_cnt[k] == '0);
        end
    end

    // Channel counters: period is sampled only while disabled or on reload
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                r_ch_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (!bus.cfg_ch_en[k]) begin
                    r_ch_cnt[k] <= bus.cfg_ch_period[k*CW +: CW];
                end else if (w_hit[k]) begin
                    r_ch_cnt[k] <= bus.cfg_ch_period[k*CW +: CW];
                end else if (w_visit[k]) begin
                    r_ch_cnt[k] <= r_ch_cnt[k] - CW'(1);
                end else begin
                    r_ch_cnt[k] <= r_ch_cnt[k];
                end
            end
        end
    end

    // Expiry strobes and sticky interrupt flags; a new expiry beats a same-cycle ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_expire   <= '0;
            r_irq_pend <= '0;
        end else begin
            r_expire   <= w_hit;
            r_irq_pend <= w_hit | (r_irq_pend & ~bus.irq_ack);
        end
    end

`ifdef TICK_SCHED_ONESHOT_EN
    logic [NCH-1:0] r_done;

    // One-shot completion: latched at expiry, rearmed by dropping the enable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (!bus.cfg_ch_en[k]) begin
                    r_done[k] <= 1'b0;
                end else if (w_hit[k] && bus.cfg_ch_oneshot[k]) begin
                    r_done[k] <= 1'b1;
                end else begin
                    r_done[k] <= r_done[k];
                end
            end
        end
    end

    assign w_done = r_done;
`else
    logic w_unused_oneshot;

    assign w_unused_oneshot = ^bus.cfg_ch_oneshot;
    assign w_done           = '0;
`endif

    assign bus.tick         = r_tick;
    assign bus.expire_pulse = r_expire;
    assign bus.irq_pend     = r_irq_pend;
    assign bus.ovr_err      = r_ovr_err;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Self-checking bench for tick_timer_sched: expiry scoreboard plus directed status checks.
module tb_tick_timer_sched;

    localparam int WD  = 10;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    int   rel;
    int   t1;
    bit   seen0;
    bit   seen1;

    tick_timer_sched_if #(.WD(WD), .NCH(NCH), .CW(CW)) bus ();

    tick_timer_sched #(.WD(WD), .NCH(NCH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // cycle index: value N means "register contents after the Nth rising edge"
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard entries are cycle*8 + channel
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (bus.expire_pulse[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_value("expire_extra", longint'(cyc * 8 + k), -1);
                end else begin
                    check_value("expire", longint'(cyc * 8 + k), longint'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int c, input int k);
        exp_q.push_back(c * 8 + k);
    endtask

    task automatic do_reset();
        bus.cfg_ch_en = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_value("reset_outs", longint'({bus.tick, bus.expire_pulse, bus.irq_pend, bus.ovr_err, bus.busy}), 0);
        reset = 1'b0;
        rel = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cfg_max_cnt    = 10'd9;
        bus.cfg_ch_en      = 4'b0000;
        bus.cfg_ch_period  = '0;
        bus.cfg_ch_oneshot = 4'b0000;
        bus.irq_ack        = 4'b0000;
        bus.ovr_clr        = 1'b0;

        // ch0 P=2: expiry every 3rd tick, sticky irq until ack
        bus.cfg_ch_period[0*CW +: CW] = 16'd2;
        do_reset();
        goto(rel + 1);
        bus.cfg_ch_en = 4'b0001;
        push_exp(rel + 32, 0);
        push_exp(rel + 62, 0);
        push_exp(rel + 92, 0);
        goto(rel + 9);
        check_value("tick_before", longint'(bus.tick), 0);
        goto(rel + 10);
        check_value("tick_first", longint'(bus.tick), 1);
        goto(rel + 11);
        check_value("tick_width", longint'(bus.tick), 0);
        goto(rel + 20);
        check_value("tick_second", longint'(bus.tick), 1);
        goto(rel + 39);
        check_value("irq0_sticky", longint'(bus.irq_pend[0]), 1);
        bus.irq_ack = 4'b0001;
        goto(rel + 40);
        bus.irq_ack = 4'b0000;
        check_value("irq0_acked", longint'(bus.irq_pend[0]), 0);
        goto(rel + 70);
        check_value("irq0_reset", longint'(bus.irq_pend[0]), 1);
        goto(rel + 95);
        check_value("t1_exp_left", longint'(exp_q.size()), 0);

        // all channels P=0: consecutive strobes T+2..T+5, busy T+1..T+4
        bus.cfg_ch_period = '0;
        do_reset();
        goto(rel + 1);
        bus.cfg_ch_en = 4'b1111;
        for (int n = 1; n <= 3; n++) begin
            for (int k = 0; k < NCH; k++) begin
                push_exp(rel + 10 * n + 2 + k, k);
            end
        end
        t1 = rel + 10;
        goto(t1);
        check_value("busy_tick", longint'(bus.busy), 0);
        goto(t1 + 1);
        check_value("busy_start", longint'(bus.busy), 1);
        goto(t1 + 4);
        check_value("busy_last", longint'(bus.busy), 1);
        goto(t1 + 5);
        check_value("busy_end", longint'(bus.busy), 0);
        goto(rel + 37);
        check_value("irq_all", longint'(bus.irq_pend), 15);
        check_value("t2_exp_left", longint'(exp_q.size()), 0);

        // tick every 2 clocks against a 4-cycle scan: overrun, and set beats clear
        bus.cfg_max_cnt = 10'd1;
        do_reset();
        goto(rel + 3);
        check_value("ovr_early", longint'(bus.ovr_err), 0);
        goto(rel + 12);
        check_value("ovr_set", longint'(bus.ovr_err), 1);
        bus.ovr_clr = 1'b1;
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            goto(cyc + 1);
            if (bus.ovr_err === 1'b1) seen1 = 1'b1;
            if (bus.ovr_err === 1'b0) seen0 = 1'b0 | 1'b1;
        end
        check_value("ovr_set_wins", longint'(seen1), 1);
        check_value("ovr_clr_works", longint'(seen0), 1);
        bus.cfg_max_cnt = 10'd9;
        goto(rel + 34);
        bus.ovr_clr = 1'b0;
        goto(rel + 36);
        check_value("ovr_cleared", longint'(bus.ovr_err), 0);
        goto(rel + 60);
        check_value("ovr_quiet", longint'(bus.ovr_err), 0);

        // ack colliding with a ch1 expiry leaves irq set
        bus.cfg_max_cnt   = 10'd9;
        bus.cfg_ch_period = '0;
        do_reset();
        goto(rel + 1);
        bus.cfg_ch_en = 4'b0010;
        for (int n = 1; n <= 3; n++) begin
            push_exp(rel + 10 * n + 3, 1);
        end
        goto(rel + 15);
        bus.irq_ack = 4'b0010;
        goto(rel + 16);
        bus.irq_ack = 4'b0000;
        check_value("irq1_ack", longint'(bus.irq_pend[1]), 0);
        goto(rel + 22);
        bus.irq_ack = 4'b0010;
        goto(rel + 23);
        bus.irq_ack = 4'b0000;
        check_value("irq1_set_wins", longint'(bus.irq_pend[1]), 1);
        goto(rel + 25);
        bus.irq_ack = 4'b0010;
        goto(rel + 26);
        bus.irq_ack = 4'b0000;
        check_value("irq1_ack_alone", longint'(bus.irq_pend[1]), 0);
        goto(rel + 37);
        check_value("t4_exp_left", longint'(exp_q.size()), 0);

        // reset at SCAN idx=2 aborts the scan; prescaler restarts from zero
        do_reset();
        goto(rel + 1);
        bus.cfg_ch_en = 4'b1111;
        t1 = rel + 10;
        push_exp(t1 + 2, 0);
        push_exp(t1 + 3, 1);
        goto(t1 + 3);
        reset = 1'b1;
        goto(t1 + 4);
        check_value("midscan_reset", longint'({bus.tick, bus.expire_pulse, bus.irq_pend, bus.ovr_err, bus.busy}), 0);
        reset = 1'b0;
        rel = cyc;
        for (int k = 0; k < NCH; k++) begin
            push_exp(rel + 12 + k, k);
        end
        goto(rel + 9);
        check_value("post_rst_no_tick", longint'(bus.tick), 0);
        goto(rel + 10);
        check_value("post_rst_tick", longint'(bus.tick), 1);
        goto(rel + 17);
        check_value("t5_exp_left", longint'(exp_q.size()), 0);

        // ch2 P=1 one-shot (periodic when the one-shot build option is off), rearm by enable toggle
        bus.cfg_ch_period = '0;
        bus.cfg_ch_period[2*CW +: CW] = 16'd1;
        bus.cfg_ch_oneshot = 4'b0100;
        do_reset();
        goto(rel + 1);
        bus.cfg_ch_en = 4'b0100;
        push_exp(rel + 24, 2);
`ifndef TICK_SCHED_ONESHOT_EN
        push_exp(rel + 44, 2);
        push_exp(rel + 64, 2);
`endif
        push_exp(rel + 84, 2);
        goto(rel + 65);
        bus.cfg_ch_en = 4'b0000;
        goto(rel + 66);
        bus.cfg_ch_en = 4'b0100;
        goto(rel + 95);
        check_value("t6_exp_left", longint'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
